// File: rtl/vector_divider_seq_pkg.sv
// ---------------------------------------------------------------------------
// vector_divider_seq_pkg
// Shared definitions for the lane-shared vector divider:
//   - default widths for the attention-tail divider (numerator, divisor,
//     quotient, fractional bits, vector length, lane count)
//   - vector typedefs at default widths for the numerator vector, the
//     softmax row-sum divisor and the normalised O row
//   - controller state encoding
// ---------------------------------------------------------------------------
package vector_divider_seq_pkg;

  localparam int DEF_VEC_LEN   = 64;
  localparam int DEF_NUM_WIDTH = 32;
  localparam int DEF_DEN_WIDTH = 16;
  localparam int DEF_Q_WIDTH   = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_LANES     = 8;

  // Numerator vector, element i at [i*NUM_WIDTH +: NUM_WIDTH]
  typedef logic [DEF_VEC_LEN*DEF_NUM_WIDTH-1:0] star_vector_t;
  // Scalar divisor (softmax row-sum l)
  typedef logic [DEF_DEN_WIDTH-1:0]             expmul_vec_qt;
  // Normalised output row, element i at [i*Q_WIDTH +: Q_WIDTH]
  typedef logic [DEF_VEC_LEN*DEF_Q_WIDTH-1:0]   o_vector_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIV   = 3'd1,
    ST_WRITE = 3'd2,
    ST_ZERO  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vector_divider_seq_div_lane.sv
// ---------------------------------------------------------------------------
// vector_divider_seq_div_lane
// One divider lane: radix-2 restoring division of |num| << FRAC_BITS by an
// unsigned divisor, one quotient bit per step, followed by combinational
// round-half-away-from-zero, sign application and saturation.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      start a new division with num (sign captured, magnitude taken)
//   step      perform one restoring step (MSB first)
//   num       signed numerator element
//   den       unsigned divisor, held stable by the controller while stepping
//   q_out     rounded, signed, saturated quotient of the finished division
// ---------------------------------------------------------------------------
module vector_divider_seq_div_lane
  import vector_divider_seq_pkg::*;
#(
  parameter int NUM_WIDTH = DEF_NUM_WIDTH,
  parameter int DEN_WIDTH = DEF_DEN_WIDTH,
  parameter int Q_WIDTH   = DEF_Q_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        step,
  input  logic signed [NUM_WIDTH-1:0] num,
  input  logic        [DEN_WIDTH-1:0] den,
  output logic signed [Q_WIDTH-1:0]   q_out
);

  localparam int ITER = NUM_WIDTH + FRAC_BITS;

  localparam logic [ITER:0] POS_LIM = (ITER+1)'({(Q_WIDTH-1){1'b1}});
  localparam logic [ITER:0] NEG_LIM = POS_LIM + (ITER+1)'(1);
  localparam logic signed [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  // Clamp a rounded magnitude into the signed quotient range and apply sign.
  function automatic logic signed [Q_WIDTH-1:0] sat_q(input logic neg,
                                                     input logic [ITER:0] mag);
    logic signed [Q_WIDTH-1:0] m;
    m = mag[Q_WIDTH-1:0];
    if (neg) begin
      if (mag > NEG_LIM) sat_q = Q_MIN;
      else               sat_q = -m;
    end else begin
      if (mag > POS_LIM) sat_q = Q_MAX;
      else               sat_q = m;
    end
  endfunction

  // Round half away from zero: 2*rem >= den, written as rem >= den - rem so
  // no extra bit is needed (rem < den always holds after a step).
  function automatic logic round_up(input logic [DEN_WIDTH:0] rem,
                                    input logic [DEN_WIDTH:0] den_x);
    round_up = (rem >= (den_x - rem));
  endfunction

  logic [ITER-1:0]    dvd_p0;   // shifted dividend magnitude, MSB consumed first
  logic [DEN_WIDTH:0] rem_p0;   // partial remainder
  logic [ITER-1:0]    quot_p0;  // quotient magnitude being built
  logic               neg_p0;   // numerator sign

  logic [NUM_WIDTH-1:0] num_mag;
  logic [DEN_WIDTH:0]   den_x;
  logic [DEN_WIDTH:0]   rem_sh;
  logic                 rem_ge;
  logic [ITER:0]        mag_rnd;

  // |-2^(NUM_WIDTH-1)| wraps to the same bit pattern, which read unsigned is
  // exactly 2^(NUM_WIDTH-1).
  assign num_mag = num[NUM_WIDTH-1] ? $unsigned(-num) : $unsigned(num);
  assign den_x   = {1'b0, den};
  assign rem_sh  = {rem_p0[DEN_WIDTH-1:0], dvd_p0[ITER-1]};
  assign rem_ge  = (rem_sh >= den_x);

  // ---- stage p0: restoring step registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_p0  <= '0;
      rem_p0  <= '0;
      quot_p0 <= '0;
      neg_p0  <= 1'b0;
    end else if (load) begin
      dvd_p0  <= ITER'(num_mag) << FRAC_BITS;
      rem_p0  <= '0;
      quot_p0 <= '0;
      neg_p0  <= num[NUM_WIDTH-1];
    end else if (step) begin
      dvd_p0  <= dvd_p0 << 1;
      rem_p0  <= rem_ge ? (rem_sh - den_x) : rem_sh;
      quot_p0 <= {quot_p0[ITER-2:0], rem_ge};
    end
  end

  // ---- result: round, sign, saturate ----
  // The extra magnitude bit absorbs the rounding carry before clamping.
  assign mag_rnd = {1'b0, quot_p0} + (ITER+1)'(round_up(rem_p0, den_x));
  assign q_out   = sat_q(neg_p0, mag_rnd);

endmodule

// File: rtl/vector_divider_seq.sv
// ---------------------------------------------------------------------------
// vector_divider_seq
// Divides every signed element of a vector by one unsigned scalar (the
// softmax row-sum l), producing a fixed-point O row with FRAC_BITS fraction
// bits, round-half-away-from-zero and saturation. LANES elements are divided
// at a time, one restoring step per cycle; groups of lanes are processed in
// turn. A zero divisor short-cuts to a saturated sign result and flags
// div_by_zero. One transaction at a time behind a valid/ready handshake.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   vld_in       upstream valid
//   rdy_out      ready to upstream (only in IDLE)
//   vec_in       numerator vector, element i at [i*NUM_WIDTH +: NUM_WIDTH]
//   divisor_in   scalar divisor
//   vld_out      result valid, held until rdy_in
//   rdy_in       downstream ready
//   vec_out      quotient vector, element i at [i*Q_WIDTH +: Q_WIDTH]
//   div_by_zero  result was produced with a zero divisor
// ---------------------------------------------------------------------------
module vector_divider_seq
  import vector_divider_seq_pkg::*;
#(
  parameter int VEC_LEN   = DEF_VEC_LEN,
  parameter int NUM_WIDTH = DEF_NUM_WIDTH,
  parameter int DEN_WIDTH = DEF_DEN_WIDTH,
  parameter int Q_WIDTH   = DEF_Q_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int LANES     = DEF_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_in,
  output logic                         rdy_out,
  input  logic [VEC_LEN*NUM_WIDTH-1:0] vec_in,
  input  logic [DEN_WIDTH-1:0]         divisor_in,
  output logic                         vld_out,
  input  logic                         rdy_in,
  output logic [VEC_LEN*Q_WIDTH-1:0]   vec_out,
  output logic                         div_by_zero
);

  localparam int ITER   = NUM_WIDTH + FRAC_BITS;
  localparam int GROUPS = VEC_LEN / LANES;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CNT_W  = $clog2(ITER);

  localparam logic [GRP_W-1:0] LAST_GROUP = GRP_W'(GROUPS - 1);
  localparam logic [CNT_W-1:0] CNT_START  = CNT_W'(ITER - 1);

  localparam logic signed [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  if (VEC_LEN % LANES != 0) begin : g_bad_lanes
    $error("vector_divider_seq: VEC_LEN must be a multiple of LANES");
  end

  // Divide-by-zero result: saturate toward the numerator's sign.
  function automatic logic signed [Q_WIDTH-1:0] zero_q(
    input logic signed [NUM_WIDTH-1:0] n);
    if (n > 0)      zero_q = Q_MAX;
    else if (n < 0) zero_q = Q_MIN;
    else            zero_q = '0;
  endfunction

  state_t                       state;
  logic [GRP_W-1:0]             group;
  logic [CNT_W-1:0]             cnt;
  logic [VEC_LEN*NUM_WIDTH-1:0] num_p0;
  logic [DEN_WIDTH-1:0]         den_p0;

  logic                         accept;
  logic                         lane_load;
  logic                         lane_step;
  logic [GRP_W-1:0]             next_group;
  logic signed [Q_WIDTH-1:0]    lane_q [LANES];

  assign accept     = (state == ST_IDLE) && vld_in && rdy_out;
  assign next_group = (group == LAST_GROUP) ? '0 : group + 1'b1;
  // Lanes load group 0 straight from the input on accept, later groups from
  // the captured vector while the current group is being written out.
  assign lane_load  = (accept && (divisor_in != '0)) ||
                      ((state == ST_WRITE) && (group != LAST_GROUP));
  assign lane_step  = (state == ST_DIV);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [NUM_WIDTH-1:0] lane_num;

    assign lane_num = (state == ST_IDLE)
                    ? vec_in[l*NUM_WIDTH +: NUM_WIDTH]
                    : num_p0[(int'(next_group)*LANES + l)*NUM_WIDTH +: NUM_WIDTH];

    vector_divider_seq_div_lane #(
      .NUM_WIDTH (NUM_WIDTH),
      .DEN_WIDTH (DEN_WIDTH),
      .Q_WIDTH   (Q_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_div_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (lane_load),
      .step  (lane_step),
      .num   (lane_num),
      .den   (den_p0),
      .q_out (lane_q[l])
    );
  end

  // ---- controller, input capture and output assembly ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rdy_out     <= 1'b0;
      vld_out     <= 1'b0;
      vec_out     <= '0;
      div_by_zero <= 1'b0;
      group       <= '0;
      cnt         <= '0;
      num_p0      <= '0;
      den_p0      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rdy_out <= 1'b1;
          if (accept) begin
            rdy_out     <= 1'b0;
            num_p0      <= vec_in;
            den_p0      <= divisor_in;
            div_by_zero <= 1'b0;
            group       <= '0;
            cnt         <= CNT_START;
            state       <= (divisor_in != '0) ? ST_DIV : ST_ZERO;
          end
        end

        ST_DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_WRITE;
        end

        ST_WRITE: begin
          for (int l = 0; l < LANES; l++) begin
            vec_out[(int'(group)*LANES + l)*Q_WIDTH +: Q_WIDTH] <= lane_q[l];
          end
          if (group == LAST_GROUP) begin
            state <= ST_DONE;
          end else begin
            group <= next_group;
            cnt   <= CNT_START;
            state <= ST_DIV;
          end
        end

        ST_ZERO: begin
          for (int i = 0; i < VEC_LEN; i++) begin
            vec_out[i*Q_WIDTH +: Q_WIDTH] <= zero_q(num_p0[i*NUM_WIDTH +: NUM_WIDTH]);
          end
          div_by_zero <= 1'b1;
          state       <= ST_DONE;
        end

        ST_DONE: begin
          // First DONE cycle raises valid; result then holds until taken.
          if (!vld_out) begin
            vld_out <= 1'b1;
          end else if (rdy_in) begin
            vld_out <= 1'b0;
            rdy_out <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_divider_seq.sv
module tb_vector_divider_seq;

  localparam int VEC_LEN   = 4;
  localparam int NUM_WIDTH = 16;
  localparam int DEN_WIDTH = 16;
  localparam int Q_WIDTH   = 16;
  localparam int FRAC_BITS = 8;
  localparam int LANES     = 2;
  localparam int LAT_DIV   = 51;
  localparam int LAT_ZERO  = 2;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         vld_in = 1'b0;
  logic                         rdy_out;
  logic [VEC_LEN*NUM_WIDTH-1:0] vec_in = '0;
  logic [DEN_WIDTH-1:0]         divisor_in = '0;
  logic                         vld_out;
  logic                         rdy_in = 1'b0;
  logic [VEC_LEN*Q_WIDTH-1:0]   vec_out;
  logic                         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  vector_divider_seq #(
    .VEC_LEN   (VEC_LEN),
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (DEN_WIDTH),
    .Q_WIDTH   (Q_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .LANES     (LANES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .rdy_out     (rdy_out),
    .vec_in      (vec_in),
    .divisor_in  (divisor_in),
    .vld_out     (vld_out),
    .rdy_in      (rdy_in),
    .vec_out     (vec_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint elem(input int i);
    logic signed [Q_WIDTH-1:0] t;
    t = vec_out[i*Q_WIDTH +: Q_WIDTH];
    return longint'(t);
  endfunction

  // Present one transaction and let it be accepted; returns #1 after the
  // accept edge (cycle 0).
  task automatic start_op(input int v0, input int v1, input int v2, input int v3,
                          input int d);
    int n;
    n = 0;
    while (!rdy_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rdy_before_accept", longint'(rdy_out), 1);
    vec_in     = {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    divisor_in = 16'(d);
    vld_in     = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    check("rdy_low_busy", longint'(rdy_out), 0);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!vld_out && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, longint'(lat), longint'(exp_lat));
  endtask

  task automatic check_vec(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input int dbz);
    check({tag, "_e0"}, elem(0), longint'(e0));
    check({tag, "_e1"}, elem(1), longint'(e1));
    check({tag, "_e2"}, elem(2), longint'(e2));
    check({tag, "_e3"}, elem(3), longint'(e3));
    check({tag, "_dbz"}, longint'(div_by_zero), longint'(dbz));
  endtask

  task automatic handshake(input string tag);
    rdy_in = 1'b1;
    @(posedge clk); #1;
    rdy_in = 1'b0;
    check({tag, "_vld_cleared"}, longint'(vld_out), 0);
    check({tag, "_rdy_back"}, longint'(rdy_out), 1);
  endtask

  task automatic run(input string tag, input int v0, input int v1, input int v2,
                     input int v3, input int d, input int lat,
                     input int e0, input int e1, input int e2, input int e3,
                     input int dbz);
    start_op(v0, v1, v2, v3, d);
    wait_result(tag, lat);
    check_vec(tag, e0, e1, e2, e3, dbz);
    handshake(tag);
  endtask

  logic [VEC_LEN*Q_WIDTH-1:0] exp_hold;
  int stale;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", longint'(rdy_out), 0);
    check("rst_vld", longint'(vld_out), 0);
    check("rst_vec", longint'(vec_out), 0);
    check("rst_dbz", longint'(div_by_zero), 0);
    rst = 1'b0;
    #1;
    check("rdy_before_edge", longint'(rdy_out), 0);
    @(posedge clk); #1;
    check("rdy_after_release", longint'(rdy_out), 1);

    // Basic division, including zero numerator
    run("basic", 3, 1, -5, 0, 2, LAT_DIV, 384, 128, -640, 0, 0);
    // Rounding with divisor 3 and exact-half cases with 512
    run("div3", 1, 1, -1, 2, 3, LAT_DIV, 85, 85, -85, 171, 0);
    run("div512", 1, 1, -1, 2, 512, LAT_DIV, 1, 1, -1, 1, 0);
    // Saturation at both ends
    run("sat", 32767, -32768, 200, -200, 1, LAT_DIV, 32767, -32768, 32767, -32768, 0);
    // Divide by zero
    run("zero", 7, -7, 0, 1, 0, LAT_ZERO, 32767, -32768, 0, 32767, 1);

    // Downstream stall with new data offered: nothing changes, nothing captured
    start_op(3, 1, -5, 0, 2);
    wait_result("hold", LAT_DIV);
    check_vec("hold", 384, 128, -640, 0, 0);
    exp_hold   = {16'sd0, -16'sd640, 16'sd128, 16'sd384};
    vec_in     = {16'sd2, -16'sd1, 16'sd1, 16'sd1};
    divisor_in = 16'd3;
    vld_in     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_vld", longint'(vld_out), 1);
      check("hold_rdy", longint'(rdy_out), 0);
      check("hold_vec", longint'(vec_out), longint'(exp_hold));
    end
    vld_in = 1'b0;
    handshake("hold");
    run("after_hold", 1, 1, -1, 2, 3, LAT_DIV, 85, 85, -85, 171, 0);

    // Asynchronous reset in the middle of the division
    start_op(3, 1, -5, 0, 2);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_vld", longint'(vld_out), 0);
    check("midrst_vec", longint'(vec_out), 0);
    check("midrst_rdy", longint'(rdy_out), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_rdy_release", longint'(rdy_out), 1);
    stale = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (vld_out) stale++;
    end
    check("midrst_no_stale_vld", longint'(stale), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_divider_seq.md
Name: vector_divider_seq

Overview:
Iterative, lane-shared successor to the per-element divider. Divides every element of a signed vector by one unsigned scalar, the softmax row-sum l, to give the normalised O row. It sits at the tail of the attention pipeline. It processes LANES elements at a time with one radix-2 restoring step per cycle. It adds fixed-point fractional output, round-to-nearest, saturation, divide-by-zero handling and a single-transaction valid/ready wrapper.

Parameters:
VEC_LEN, 64, elements per vector.
NUM_WIDTH, 32, signed numerator element width.
DEN_WIDTH, 16, unsigned divisor width.
Q_WIDTH, 16, signed quotient element width.
FRAC_BITS, 8, fractional bits in the quotient; the numerator is shifted left by FRAC_BITS before dividing.
LANES, 8, parallel divider lanes; VEC_LEN % LANES must equal 0, otherwise an elaboration error.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
vld_in  in  1  upstream valid
rdy_out  out  1  ready to upstream
vec_in  in  VEC_LEN*NUM_WIDTH  numerator vector (element i at [i*NUM_WIDTH +: NUM_WIDTH])
divisor_in  in  DEN_WIDTH  scalar divisor l
vld_out  out  1  result valid to downstream
rdy_in  in  1  downstream ready
vec_out  out  VEC_LEN*Q_WIDTH  quotient vector
div_by_zero  out  1  result was produced with divisor == 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. All state is in flops cleared by rst.
- Reset values: rdy_out=0, vld_out=0, vec_out=0, div_by_zero=0, state=IDLE.
  - rdy_out rises on the first clk edge after rst deasserts.
- Derived constants: ITER = NUM_WIDTH+FRAC_BITS, GROUPS = VEC_LEN/LANES.
- States:
  - IDLE: rdy_out=1.
    - On vld_in&&rdy_out, capture vec_in and divisor_in, and drop rdy_out.
    - divisor_in != 0: go to DIV with group=0 and bit counter=ITER-1.
    - divisor_in == 0: go to ZERO.
  - DIV: each lane does one restoring step on |num|<<FRAC_BITS against the divisor, MSB first.
    - The counter decrements each cycle. Go to WRITE when the counter reaches 0.
  - WRITE (1 cycle), per lane:
    - Round half away from zero: increment the magnitude if 2*remainder >= divisor.
    - Apply the numerator sign.
    - Saturate: positive results clamp to 2^(Q_WIDTH-1)-1; negative results clamp to -2^(Q_WIDTH-1).
    - Store into vec_out slots group*LANES .. group*LANES+LANES-1.
    - If group == GROUPS-1, go to DONE. Otherwise increment group, reload the counter and go to DIV.
  - ZERO (1 cycle): each element becomes +max if num>0, -min if num<0, 0 if num==0. Set div_by_zero=1 and go to DONE.
  - DONE: vld_out=1.
    - vec_out and div_by_zero stay stable until vld_out&&rdy_in.
    - On vld_out&&rdy_in: vld_out=0, go to IDLE. rdy_out=1 on the following cycle.
- Latency, counting the accept edge as cycle 0:
  - Normal path: vld_out high from cycle GROUPS*(ITER+1)+1. Defaults give 329.
  - Zero path: vld_out high from cycle 2.
- No overlap: rdy_out=0 in every state except IDLE. vld_in outside IDLE is ignored. div_by_zero clears on the next accept.
- Numerator zero with a nonzero divisor gives 0.
- Back-to-back: the earliest next accept is 1 cycle after the handshake.
- Reset mid-operation (any state): immediate return to reset values. The partial result is discarded and no vld_out is produced.
- Internal widths:
  - Partial remainder is DEN_WIDTH+1 bits.
  - Magnitude quotient is ITER+1 bits, so the rounding carry cannot overflow before saturation.
  - |-2^(NUM_WIDTH-1)| is represented exactly.

Decomposition:
- Shared package/header holds:
  - vector typedefs for the numerator vector, divisor scalar and O vector (existing STAR_VECTOR_T / EXPMUL_VEC_QT / O_VECTOR_T family);
  - the state enum;
  - the default FRAC_BITS/Q_WIDTH constants.
- Sub-module div_lane holds one lane's remainder/quotient registers, restoring step, rounding and saturation.
  - It is instantiated LANES times by a generate loop.
  - The top module owns the FSM, counters, input capture and output assembly.

Test Plan:
Test config: VEC_LEN=4, LANES=2, NUM_WIDTH=16, DEN_WIDTH=16, Q_WIDTH=16, FRAC_BITS=8 (ITER=24, latency 51).
- vec_in={3,1,-5,0}, divisor=2 -> vec_out={384,128,-640,0}; vld_out first at cycle 51; div_by_zero=0.
- vec_in={1,1,-1,2}, divisor=3 and divisor=512 -> with 3: {85,85,-85,171}; with 512: {1,1,-1,1} (half rounds away from zero).
- vec_in={32767,-32768,200,-200}, divisor=1 -> {32767,-32768,32767,-32768} (saturation).
- divisor=0, vec_in={7,-7,0,1} -> {32767,-32768,0,32767}; div_by_zero=1; vld_out at cycle 2.
- Hold rdy_in=0 for 10 cycles in DONE while vld_in=1 with new data -> vec_out and vld_out stay stable, rdy_out=0, new data is not captured. Release rdy_in -> IDLE, and the next accept yields the correct second result.
- Assert rst asynchronously at cycle 20 of DIV -> vld_out=0 and vec_out=0 immediately; rdy_out=1 one edge after release; no stale vld_out afterwards.
